// File: rtl/fdivsqrtpreprocseq_if.sv
// Bundle of the fdivsqrtpreprocseq request/response signals: operands and handshake from the
// execute stage, plus the preprocessed results handed to the iteration FSM.
`default_nettype none

interface fdivsqrtpreprocseq_if #(
  parameter int XLEN    = 64,
  parameter int DIVb    = 64,
  parameter int DIVBLEN = 7
);
  logic              StartE;
  logic              FlushE;
  logic [XLEN-1:0]   ForwardedSrcAE;
  logic [XLEN-1:0]   ForwardedSrcBE;
  logic [2:0]        Funct3E;
  logic              W64E;
  logic              ReadyE;
  logic              DoneM;
  logic              AckM;
  logic [DIVb+3:0]   X;
  logic [DIVb+3:0]   D;
  logic [DIVBLEN:0]  nM;
  logic [DIVBLEN:0]  mM;
  logic              ISpecialCaseM;
  logic              ALTBM;
  logic              BZeroM;
  logic              NegQuotM;
  logic              AsM;
  logic [XLEN-1:0]   AM;

  modport master (
    output StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E, AckM,
    input  ReadyE, DoneM, X, D, nM, mM, ISpecialCaseM, ALTBM, BZeroM, NegQuotM, AsM, AM
  );

  modport slave (
    input  StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E, AckM,
    output ReadyE, DoneM, X, D, nM, mM, ISpecialCaseM, ALTBM, BZeroM, NegQuotM, AsM, AM
  );
endinterface

`default_nettype wire

// File: rtl/fdivsqrtpreprocseq.sv
// Multi-cycle integer divide preprocessing: sign handling, iterative SHSTEP-wide normalisation
// and digit alignment of the dividend. Optional W64 support under macro FDIVPRE_W64_EN.
`default_nettype none

module fdivsqrtpreprocseq #(
  parameter int XLEN      = 64,
  parameter int DIVb      = 64,
  parameter int DIVBLEN   = 7,
  parameter int LOGR      = 1,
  parameter int DIVCOPIES = 2,
  parameter int SHSTEP    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fdivsqrtpreprocseq_if.slave  bus
);
  localparam int RK    = LOGR * DIVCOPIES;
  localparam int LOGRK = $clog2(RK);
  localparam int LZW   = (SHSTEP > 1) ? $clog2(SHSTEP) : 1;
  localparam int SHW   = (LOGRK > 0) ? LOGRK : 1;
  localparam logic [DIVBLEN:0] C_SHSTEP = (DIVBLEN+1)'(SHSTEP);
  localparam logic [DIVBLEN:0] C_LOGR   = (DIVBLEN+1)'(LOGR);
  localparam logic [DIVBLEN:0] C_COPIES = (DIVBLEN+1)'(DIVCOPIES);
  localparam logic [DIVBLEN:0] C_ONE    = (DIVBLEN+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_NORM = 3'd2, S_ALIGN = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   src_a_q, src_a_d, src_b_q, src_b_d;
  logic              signed_q, signed_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, ae_q, ae_d;
  logic [DIVBLEN:0]  ell_q, ell_d, m_q, m_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_zero_q, a_zero_d, b_zero_q, b_zero_d, as_q, as_d, neg_q, neg_d;
  logic [DIVb+3:0]   x_out_q, x_out_d, d_out_q, d_out_d;
  logic [DIVBLEN:0]  n_out_q, n_out_d, m_out_q, m_out_d;
  logic              isp_q, isp_d, altb_q, altb_d, bzero_out_q, bzero_out_d;
  logic              negq_out_q, negq_out_d, as_out_q, as_out_d, done_q, done_d;
  logic [XLEN-1:0]   am_out_q, am_out_d;

  logic [XLEN-1:0]   a_e, b_e;
  logic              as_w, bs_w, accept, unused_in;
  logic [SHSTEP-1:0] a_win, b_win;
  logic [LZW-1:0]    a_lz, b_lz;
  logic [DIVBLEN:0]  zero_diff, p, n_align;
  logic              altb, isp;
  logic [SHW-1:0]    rsh;
  logic [DIVb+3:0]   x_pre;

`ifdef FDIVPRE_W64_EN
  logic w64_q, w64_d;
  assign a_e = w64_q ? {{(XLEN-32){signed_q & src_a_q[31]}}, src_a_q[31:0]} : src_a_q;
  assign b_e = w64_q ? {{(XLEN-32){signed_q & src_b_q[31]}}, src_b_q[31:0]} : src_b_q;
  assign unused_in = ^bus.Funct3E[2:1];
`else
  assign a_e = src_a_q;
  assign b_e = src_b_q;
  assign unused_in = ^{bus.Funct3E[2:1], bus.W64E};
`endif

  assign as_w = a_e[XLEN-1] & signed_q;
  assign bs_w = b_e[XLEN-1] & signed_q;

  function automatic logic [LZW-1:0] lzc(input logic [SHSTEP-1:0] w);
    logic [LZW-1:0] lz;
    lz = '0;
    for (int i = 0; i < SHSTEP; i++)
      if (w[i]) lz = LZW'(SHSTEP - 1 - i);
    return lz;
  endfunction

  assign a_win = a_q[XLEN-1 -: SHSTEP];
  assign b_win = b_q[XLEN-1 -: SHSTEP];
  assign a_lz  = lzc(a_win);
  assign b_lz  = lzc(b_win);

  // Alignment math, evaluated from the normalised operands held in a_q/b_q.
  assign zero_diff = m_q - ell_q;
  assign altb      = zero_diff[DIVBLEN] | a_zero_q;
  assign p         = altb ? '0 : zero_diff;
  assign isp       = b_zero_q | altb;

  if (LOGRK == 0) begin : g_rk_one
    assign n_align = p;
    assign rsh     = '0;
  end else begin : g_rk_multi
    logic [DIVBLEN:0] tib, int_steps;
    logic [LOGRK-1:0] tib_lo_m1;
    assign tib       = C_LOGR + p;
    assign int_steps = (tib >> LOGRK) + {{DIVBLEN{1'b0}}, |tib[LOGRK-1:0]};
    assign n_align   = (int_steps * C_COPIES) - C_ONE;
    assign tib_lo_m1 = tib[LOGRK-1:0] - LOGRK'(1);
    assign rsh       = ~tib_lo_m1;
  end

  assign x_pre = {3'b000, ~a_zero_q, a_q[XLEN-2:0], {(DIVb-XLEN+1){1'b0}}};

  always_comb begin
    state_d = state_q;   src_a_d = src_a_q;     src_b_d = src_b_q;   signed_d = signed_q;
    a_d = a_q;           b_d = b_q;             ae_d = ae_q;         ell_d = ell_q;
    m_d = m_q;           a_done_d = a_done_q;   b_done_d = b_done_q;
    a_zero_d = a_zero_q; b_zero_d = b_zero_q;   as_d = as_q;         neg_d = neg_q;
    x_out_d = x_out_q;   d_out_d = d_out_q;     n_out_d = n_out_q;   m_out_d = m_out_q;
    isp_d = isp_q;       altb_d = altb_q;       bzero_out_d = bzero_out_q;
    negq_out_d = negq_out_q; as_out_d = as_out_q; am_out_d = am_out_q; done_d = done_q;
`ifdef FDIVPRE_W64_EN
    w64_d = w64_q;
`endif
    accept = bus.StartE & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.AckM));
    case (state_q)
      S_IDLE: if (bus.StartE) state_d = S_LOAD;
      S_LOAD: begin
        ae_d     = a_e;
        as_d     = as_w;
        neg_d    = as_w ^ bs_w;
        a_d      = as_w ? -a_e : a_e;
        b_d      = bs_w ? -b_e : b_e;
        a_zero_d = (a_e == '0);
        b_zero_d = (b_e == '0);
        ell_d    = '0;
        m_d      = '0;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        state_d  = ((a_e == '0) | (b_e == '0)) ? S_ALIGN : S_NORM;
      end
      S_NORM: begin
        if (!a_done_q) begin
          if (a_win == '0) begin
            a_d = a_q << SHSTEP;  ell_d = ell_q + C_SHSTEP;
          end else begin
            a_d = a_q << a_lz;    ell_d = ell_q + (DIVBLEN+1)'(a_lz);  a_done_d = 1'b1;
          end
        end
        if (!b_done_q) begin
          if (b_win == '0) begin
            b_d = b_q << SHSTEP;  m_d = m_q + C_SHSTEP;
          end else begin
            b_d = b_q << b_lz;    m_d = m_q + (DIVBLEN+1)'(b_lz);    b_done_d = 1'b1;
          end
        end
        if (a_done_d & b_done_d) state_d = S_ALIGN;
      end
      S_ALIGN: begin
        x_out_d     = x_pre >> rsh;
        d_out_d     = {4'b0001, b_q[XLEN-2:0], {(DIVb-XLEN+1){1'b0}}};
        // Special cases bypass the iterator, so no fractional digits are requested.
        n_out_d     = isp ? '0 : n_align;
        m_out_d     = m_q;
        isp_d       = isp;
        altb_d      = altb;
        bzero_out_d = b_zero_q;
        negq_out_d  = neg_q;
        as_out_d    = as_q;
        am_out_d    = ae_q;
        done_d      = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: if (bus.AckM) begin
        done_d  = 1'b0;
        state_d = bus.StartE ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      src_a_d  = bus.ForwardedSrcAE;
      src_b_d  = bus.ForwardedSrcBE;
      signed_d = ~bus.Funct3E[0];
`ifdef FDIVPRE_W64_EN
      w64_d    = bus.W64E;
`endif
    end
    if (bus.FlushE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  src_a_q <= '0;  src_b_q <= '0;  signed_q <= 1'b0;
      a_q <= '0;  b_q <= '0;  ae_q <= '0;  ell_q <= '0;  m_q <= '0;
      a_done_q <= 1'b0;  b_done_q <= 1'b0;  a_zero_q <= 1'b0;  b_zero_q <= 1'b0;
      as_q <= 1'b0;  neg_q <= 1'b0;
      x_out_q <= '0;  d_out_q <= '0;  n_out_q <= '0;  m_out_q <= '0;
      isp_q <= 1'b0;  altb_q <= 1'b0;  bzero_out_q <= 1'b0;  negq_out_q <= 1'b0;
      as_out_q <= 1'b0;  am_out_q <= '0;  done_q <= 1'b0;
`ifdef FDIVPRE_W64_EN
      w64_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  src_a_q <= src_a_d;  src_b_q <= src_b_d;  signed_q <= signed_d;
      a_q <= a_d;  b_q <= b_d;  ae_q <= ae_d;  ell_q <= ell_d;  m_q <= m_d;
      a_done_q <= a_done_d;  b_done_q <= b_done_d;  a_zero_q <= a_zero_d;  b_zero_q <= b_zero_d;
      as_q <= as_d;  neg_q <= neg_d;
      x_out_q <= x_out_d;  d_out_q <= d_out_d;  n_out_q <= n_out_d;  m_out_q <= m_out_d;
      isp_q <= isp_d;  altb_q <= altb_d;  bzero_out_q <= bzero_out_d;  negq_out_q <= negq_out_d;
      as_out_q <= as_out_d;  am_out_q <= am_out_d;  done_q <= done_d;
`ifdef FDIVPRE_W64_EN
      w64_q <= w64_d;
`endif
    end
  end

  assign bus.ReadyE        = (state_q == S_IDLE) | (state_q == S_DONE);
  assign bus.DoneM         = done_q;
  assign bus.X             = x_out_q;
  assign bus.D             = d_out_q;
  assign bus.nM            = n_out_q;
  assign bus.mM            = m_out_q;
  assign bus.ISpecialCaseM = isp_q;
  assign bus.ALTBM         = altb_q;
  assign bus.BZeroM        = bzero_out_q;
  assign bus.NegQuotM      = negq_out_q;
  assign bus.AsM           = as_out_q;
  assign bus.AM            = am_out_q;
endmodule

`default_nettype wire
